// File: rtl/matrix_mult_stream.sv
// matrix_mult_stream: streaming N x N unsigned matrix multiplier.
// Loads A then B as packed beats, computes one C element per cycle with
// MATRIX_WIDTH parallel multipliers, then streams C out under read_en/read_ready.
// Optional macro SATURATE_EN: clamp each C element to 2^WIDTH-1 instead of
// keeping the low WIDTH bits of the accumulator.
module matrix_mult_stream #(
  parameter int WIDTH        = 8,
  parameter int NUM_ELEMENTS = 4,
  parameter int MATRIX_WIDTH = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NUM_ELEMENTS*WIDTH-1:0] wdata,
  input  logic                          write_en,
  output logic                          write_ready,
  input  logic                          read_en,
  output logic                          read_ready,
  output logic [NUM_ELEMENTS*WIDTH-1:0] Res
);

  localparam int NN     = MATRIX_WIDTH * MATRIX_WIDTH;
  localparam int BPM    = NN / NUM_ELEMENTS;
  localparam int BEAT_W = (BPM > 1) ? $clog2(BPM) : 1;
  localparam int EL_W   = $clog2(NN);
  localparam int ACC_W  = 2 * WIDTH + $clog2(MATRIX_WIDTH);

  typedef enum logic [1:0] {
    LOAD_A,
    LOAD_B,
    COMPUTE,
    DRAIN
  } state_t;

  state_t state, state_next;

  logic [WIDTH-1:0] a_mem [NN];
  logic [WIDTH-1:0] b_mem [NN];
  logic [WIDTH-1:0] c_mem [NN];

  logic [BEAT_W-1:0] wbeat;
  logic [BEAT_W-1:0] rbeat;
  logic [EL_W-1:0]   idx;

  logic accept, consume;
  logic wlast, rlast, idx_last;

  int unsigned       row, col;
  logic [2*WIDTH-1:0] prod [MATRIX_WIDTH];
  logic [ACC_W-1:0]   acc;
  logic [WIDTH-1:0]   c_val;

  assign accept   = write_en & write_ready;
  assign consume  = read_en & read_ready;
  assign wlast    = (wbeat == BEAT_W'(BPM - 1));
  assign rlast    = (rbeat == BEAT_W'(BPM - 1));
  assign idx_last = (idx == EL_W'(NN - 1));

  // State register
  always_ff @(posedge clk) begin
    if (reset) state <= LOAD_A;
    else       state <= state_next;
  end

  // Next-state and handshake outputs
  always_comb begin
    state_next  = state;
    write_ready = 1'b0;
    read_ready  = 1'b0;
    case (state)
      LOAD_A: begin
        write_ready = 1'b1;
        if (accept && wlast) state_next = LOAD_B;
      end
      LOAD_B: begin
        write_ready = 1'b1;
        if (accept && wlast) state_next = COMPUTE;
      end
      COMPUTE: begin
        if (idx_last) state_next = DRAIN;
      end
      DRAIN: begin
        read_ready = 1'b1;
        if (consume && rlast) state_next = LOAD_A;
      end
      default: state_next = LOAD_A;
    endcase
  end

  // Dot product of row i of A with column j of B for the current idx
  always_comb begin
    row = 32'(idx) / MATRIX_WIDTH;
    col = 32'(idx) % MATRIX_WIDTH;
    acc = '0;
    for (int unsigned k = 0; k < MATRIX_WIDTH; k++) begin
      prod[k] = (2*WIDTH)'(a_mem[EL_W'(row * MATRIX_WIDTH + k)]) *
                (2*WIDTH)'(b_mem[EL_W'(k * MATRIX_WIDTH + col)]);
      acc = acc + ACC_W'(prod[k]);
    end
  end

`ifdef SATURATE_EN
  // Clamp the accumulator to the element range
  always_comb begin
    c_val = (acc > ACC_W'({WIDTH{1'b1}})) ? '1 : acc[WIDTH-1:0];
  end
`else
  logic acc_hi_unused;

  // Keep the low WIDTH bits; high accumulator bits are deliberately dropped
  always_comb begin
    c_val         = acc[WIDTH-1:0];
    acc_hi_unused = ^acc[ACC_W-1:WIDTH];
  end
`endif

  // Matrix storage: beat writes into A/B, one C element per compute cycle
  always_ff @(posedge clk) begin
    if (!reset) begin
      if (accept) begin
        for (int unsigned e = 0; e < NUM_ELEMENTS; e++) begin
          if (state == LOAD_A)
            a_mem[EL_W'(32'(wbeat) * NUM_ELEMENTS + e)] <= wdata[e*WIDTH +: WIDTH];
          else
            b_mem[EL_W'(32'(wbeat) * NUM_ELEMENTS + e)] <= wdata[e*WIDTH +: WIDTH];
        end
      end
      if (state == COMPUTE) c_mem[idx] <= c_val;
    end
  end

  // Beat/element counters and the registered result beat.
  // Beat 0 never contains the last C element, so it can be read from c_mem
  // on the same edge that writes that element.
  always_ff @(posedge clk) begin
    if (reset) begin
      wbeat <= '0;
      rbeat <= '0;
      idx   <= '0;
      Res   <= '0;
    end else begin
      if (accept) wbeat <= wlast ? '0 : wbeat + 1'b1;
      if (state == COMPUTE) begin
        idx <= idx_last ? '0 : idx + 1'b1;
        if (idx_last) begin
          for (int unsigned e = 0; e < NUM_ELEMENTS; e++)
            Res[e*WIDTH +: WIDTH] <= c_mem[EL_W'(e)];
        end
      end
      if (consume) begin
        if (rlast) begin
          rbeat <= '0;
        end else begin
          rbeat <= rbeat + 1'b1;
          for (int unsigned e = 0; e < NUM_ELEMENTS; e++)
            Res[e*WIDTH +: WIDTH] <= c_mem[EL_W'((32'(rbeat) + 1) * NUM_ELEMENTS + e)];
        end
      end
    end
  end

endmodule

// File: tb/tb_matrix_mult_stream.sv
// Directed self-checking bench for matrix_mult_stream (default 8-bit 4x4x4
// instance plus a 16-bit, 2-elements-per-beat instance).
module tb_matrix_mult_stream;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] wdata, res;
  logic        write_en, write_ready, read_en, read_ready;
  logic [31:0] wdata2, res2;
  logic        write_en2, write_ready2, read_en2, read_ready2;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  matrix_mult_stream #(.WIDTH(8), .NUM_ELEMENTS(4), .MATRIX_WIDTH(4)) dut (
    .clk(clk), .reset(reset), .wdata(wdata), .write_en(write_en),
    .write_ready(write_ready), .read_en(read_en), .read_ready(read_ready),
    .Res(res)
  );

  matrix_mult_stream #(.WIDTH(16), .NUM_ELEMENTS(2), .MATRIX_WIDTH(4)) dut2 (
    .clk(clk), .reset(reset), .wdata(wdata2), .write_en(write_en2),
    .write_ready(write_ready2), .read_en(read_en2), .read_ready(read_ready2),
    .Res(res2)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Offer four beats back-to-back on the default instance
  task automatic load4(input logic [31:0] b0, b1, b2, b3);
    logic [31:0] bs [4];
    bs = '{b0, b1, b2, b3};
    for (int k = 0; k < 4; k++) begin
      write_en = 1'b1;
      wdata    = bs[k];
      step();
    end
    write_en = 1'b0;
  endtask

  // Bounded wait for read_ready on the default instance
  task automatic wait_rr(output bit ok);
    ok = 1'b0;
    for (int c = 0; c < 64; c++) begin
      if (read_ready === 1'b1) begin
        ok = 1'b1;
        return;
      end
      step();
    end
  endtask

  task automatic test_reset();
    checks++;
    if (write_ready !== 1'b1) begin errors++; $display("FAIL reset_write_ready got %b want 1", write_ready); end
    checks++;
    if (read_ready !== 1'b0) begin errors++; $display("FAIL reset_read_ready got %b want 0", read_ready); end
    checks++;
    if (res !== 32'h0) begin errors++; $display("FAIL reset_res got %h want 00000000", res); end
    checks++;
    if (write_ready2 !== 1'b1 || read_ready2 !== 1'b0 || res2 !== 32'h0) begin
      errors++;
      $display("FAIL reset_dut2 got wr=%b rr=%b res=%h want 1 0 00000000", write_ready2, read_ready2, res2);
    end
  endtask

  task automatic test_all_ones();
    load4(32'h01010101, 32'h01010101, 32'h01010101, 32'h01010101);
    load4(32'h01010101, 32'h01010101, 32'h01010101, 32'h01010101);
    checks++;
    if (write_ready !== 1'b0) begin errors++; $display("FAIL ones_wr_after_T got %b want 0", write_ready); end
    for (int c = 1; c <= 16; c++) begin
      step();
      checks++;
      if (read_ready !== (c == 16)) begin
        errors++;
        $display("FAIL ones_latency cycle %0d got rr=%b want %b", c, read_ready, (c == 16));
      end
    end
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (read_ready !== 1'b1 || res !== 32'h04040404) begin
        errors++;
        $display("FAIL ones_beat%0d got rr=%b res=%h want 1 04040404", k, read_ready, res);
      end
      read_en = 1'b1;
      step();
    end
    read_en = 1'b0;
    checks++;
    if (read_ready !== 1'b0 || write_ready !== 1'b1) begin
      errors++;
      $display("FAIL ones_end_handshake got rr=%b wr=%b want 0 1", read_ready, write_ready);
    end
    checks++;
    if (res !== 32'h04040404) begin errors++; $display("FAIL ones_res_hold got %h want 04040404", res); end
  endtask

  task automatic test_identity();
    logic [31:0] exp [4];
    bit ok;
    exp = '{32'h04030201, 32'h08070605, 32'h0C0B0A09, 32'h100F0E0D};
    load4(32'h00000001, 32'h00000100, 32'h00010000, 32'h01000000);
    load4(exp[0], exp[1], exp[2], exp[3]);
    wait_rr(ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL ident_timeout got rr=%b want 1", read_ready); end
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (res !== exp[k]) begin errors++; $display("FAIL ident_beat%0d got %h want %h", k, res, exp[k]); end
      read_en = 1'b1;
      step();
    end
    read_en = 1'b0;
  endtask

  task automatic test_overflow();
    logic [31:0] want;
    bit ok;
`ifdef SATURATE_EN
    want = 32'hFFFFFFFF;
`else
    want = 32'h04040404;
`endif
    load4(32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF);
    load4(32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF);
    wait_rr(ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL ovf_timeout got rr=%b want 1", read_ready); end
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (res !== want) begin errors++; $display("FAIL ovf_beat%0d got %h want %h", k, res, want); end
      read_en = 1'b1;
      step();
    end
    read_en = 1'b0;
  endtask

  task automatic test_backpressure();
    logic [31:0] exp [4];
    bit ok;
    exp = '{32'h04030201, 32'h08070605, 32'h0C0B0A09, 32'h100F0E0D};
    load4(32'h00000001, 32'h00000100, 32'h00010000, 32'h01000000);
    load4(exp[0], exp[1], exp[2], exp[3]);
    wait_rr(ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL bp_timeout got rr=%b want 1", read_ready); end
    checks++;
    if (res !== exp[0]) begin errors++; $display("FAIL bp_beat0 got %h want %h", res, exp[0]); end
    read_en = 1'b1;
    step();
    read_en = 1'b0;
    for (int c = 0; c < 5; c++) begin
      checks++;
      if (res !== exp[1] || read_ready !== 1'b1 || write_ready !== 1'b0) begin
        errors++;
        $display("FAIL bp_stall%0d got res=%h rr=%b wr=%b want %h 1 0", c, res, read_ready, write_ready, exp[1]);
      end
      write_en = 1'b1;
      wdata    = 32'hDEADBEEF;
      step();
      write_en = 1'b0;
    end
    for (int k = 1; k < 4; k++) begin
      checks++;
      if (res !== exp[k]) begin errors++; $display("FAIL bp_beat%0d got %h want %h", k, res, exp[k]); end
      read_en = 1'b1;
      step();
    end
    read_en = 1'b0;
    checks++;
    if (read_ready !== 1'b0 || write_ready !== 1'b1 || res !== exp[3]) begin
      errors++;
      $display("FAIL bp_end got rr=%b wr=%b res=%h want 0 1 %h", read_ready, write_ready, res, exp[3]);
    end
  endtask

  task automatic test_reset_mid_compute();
    bit ok;
    load4(32'h02020202, 32'h02020202, 32'h02020202, 32'h02020202);
    load4(32'h02020202, 32'h02020202, 32'h02020202, 32'h02020202);
    for (int c = 0; c < 7; c++) step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    checks++;
    if (write_ready !== 1'b1 || read_ready !== 1'b0 || res !== 32'h0) begin
      errors++;
      $display("FAIL midrst_state got wr=%b rr=%b res=%h want 1 0 00000000", write_ready, read_ready, res);
    end
    load4(32'h01010101, 32'h01010101, 32'h01010101, 32'h01010101);
    load4(32'h01010101, 32'h01010101, 32'h01010101, 32'h01010101);
    wait_rr(ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL midrst_timeout got rr=%b want 1", read_ready); end
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (res !== 32'h04040404) begin errors++; $display("FAIL midrst_beat%0d got %h want 04040404", k, res); end
      read_en = 1'b1;
      step();
    end
    read_en = 1'b0;
  endtask

  task automatic test_parametric();
    for (int k = 0; k < 16; k++) begin
      write_en2 = 1'b1;
      wdata2    = 32'h00020002;
      step();
    end
    write_en2 = 1'b0;
    checks++;
    if (write_ready2 !== 1'b0) begin errors++; $display("FAIL param_wr_after_T got %b want 0", write_ready2); end
    for (int c = 1; c <= 16; c++) begin
      step();
      checks++;
      if (read_ready2 !== (c == 16)) begin
        errors++;
        $display("FAIL param_latency cycle %0d got rr=%b want %b", c, read_ready2, (c == 16));
      end
    end
    for (int k = 0; k < 8; k++) begin
      checks++;
      if (read_ready2 !== 1'b1 || res2 !== 32'h00100010) begin
        errors++;
        $display("FAIL param_beat%0d got rr=%b res=%h want 1 00100010", k, read_ready2, res2);
      end
      read_en2 = 1'b1;
      step();
    end
    read_en2 = 1'b0;
    checks++;
    if (read_ready2 !== 1'b0 || write_ready2 !== 1'b1) begin
      errors++;
      $display("FAIL param_end got rr=%b wr=%b want 0 1", read_ready2, write_ready2);
    end
  endtask

  initial begin
    reset     = 1'b1;
    write_en  = 1'b0;
    read_en   = 1'b0;
    wdata     = '0;
    write_en2 = 1'b0;
    read_en2  = 1'b0;
    wdata2    = '0;
    step();
    step();
    reset = 1'b0;
    test_reset();
    test_all_ones();
    test_identity();
    test_overflow();
    test_backpressure();
    test_reset_mid_compute();
    test_parametric();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
